microsequencer: RTL and testbench



---
 rtl/cu_pkg.sv | 25 ++
 rtl/moc_watchdog.sv | 45 ++++
 rtl/microsequencer.sv | 115 +++++++++++
 tb/tb_microsequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the microprogrammed control unit.
//   n_sel_e    : next-state select encodings carried in each microinstruction
//   ST_*       : well-known control-state addresses
//   WD_W       : width of the MOC-wait watchdog counter (covers TIMEOUT up to 255)
package cu_pkg;

  typedef enum logic [2:0] {
    NS_DECODE = 3'b000,
    NS_INC    = 3'b001,
    NS_JUMP   = 3'b010,
    NS_CJUMP  = 3'b011,
    NS_WAIT   = 3'b100,
    NS_CALL   = 3'b101,
    NS_RET    = 3'b110,
    NS_HOLD   = 3'b111
  } n_sel_e;

  localparam logic [5:0] ST_FETCH     = 6'd0;
  localparam logic [5:0] ST_ENC_RESET = 6'd60;
  localparam logic [5:0] ST_FAULT     = 6'd62;
  localparam logic [5:0] ST_UNDEF     = 6'd63;

  localparam int unsigned WD_W = 8;

endpackage

// File: rtl/moc_watchdog.sv
// MOC-wait watchdog: counts consecutive stalled cycles and flags a timeout
// on the TIMEOUT-th one.
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   wait_en in  high while the sequencer is stalled in a MOC wait
//   clear   in  restart counting (stall ended or left the wait)
//   timeout out high in the cycle that completes TIMEOUT stalled cycles
module moc_watchdog
  import cu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  input  logic clear,
  output logic timeout
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d   = cnt_q + 1'b1;
    timeout = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (wait_en && cnt_q == LAST) begin
      timeout = 1'b1;
      cnt_d   = '0;
    end else if (!wait_en) begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogrammed control-unit sequencer. Holds the current control state
// and selects the next one from decode, increment, jump, conditional jump,
// MOC wait, one-level call/return or halt.
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   enc_state in  decoded start state from the instruction encoder
//   n_sel     in  next-state select field of the current microinstruction
//   cr_addr   in  target address field of the current microinstruction
//   inv       in  invert the condition for CJUMP
//   cond_true in  condition-code test result
//   moc       in  memory operation complete
//   state     out current control state (registered)
//   ret_addr  out one-level return register (registered)
//   moc_wait  out stalled in a MOC wait (combinational)
//   bus_fault out sticky MOC-timeout flag (registered)
//   undef     out one-cycle pulse after decoding UNDEF_CODE (registered)
module microsequencer
  import cu_pkg::*;
#(
  parameter logic [5:0]  RESET_STATE = ST_FETCH,
  parameter logic [5:0]  FAULT_STATE = ST_FAULT,
  parameter logic [5:0]  UNDEF_CODE  = ST_UNDEF,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] enc_state,
  input  logic [2:0] n_sel,
  input  logic [5:0] cr_addr,
  input  logic       inv,
  input  logic       cond_true,
  input  logic       moc,
  output logic [5:0] state,
  output logic [5:0] ret_addr,
  output logic       moc_wait,
  output logic       bus_fault,
  output logic       undef
);

  logic [5:0] state_q, state_d;
  logic [5:0] ret_addr_q, ret_addr_d;
  logic       bus_fault_q, bus_fault_d;
  logic       undef_q, undef_d;
  logic [5:0] inc;
  logic       timeout;

  // Any cycle that is not a stall (left WAIT, or moc arrived) restarts the
  // count; during a stall the state cannot change except via the timeout.
  moc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .wait_en (moc_wait),
    .clear   (!moc_wait),
    .timeout (timeout)
  );

  assign inc = state_q + 6'd1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      ret_addr_q  <= '0;
      bus_fault_q <= 1'b0;
      undef_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_addr_q  <= ret_addr_d;
      bus_fault_q <= bus_fault_d;
      undef_q     <= undef_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ret_addr_d  = ret_addr_q;
    bus_fault_d = bus_fault_q;
    undef_d     = 1'b0;
    unique case (n_sel_e'(n_sel))
      NS_DECODE: begin
        state_d = enc_state;
        undef_d = (enc_state == UNDEF_CODE);
      end
      NS_INC:   state_d = inc;
      NS_JUMP:  state_d = cr_addr;
      NS_CJUMP: state_d = (cond_true ^ inv) ? cr_addr : inc;
      NS_WAIT: begin
        if (moc) begin
          state_d = inc;
        end else if (timeout) begin
          state_d     = FAULT_STATE;
          bus_fault_d = 1'b1;
        end
      end
      NS_CALL: begin
        ret_addr_d = inc;
        state_d    = cr_addr;
      end
      NS_RET:  state_d = ret_addr_q;
      NS_HOLD: state_d = state_q;
      default: state_d = state_q;
    endcase
  end

  // Outputs
  always_comb begin
    moc_wait  = (n_sel_e'(n_sel) == NS_WAIT) && !moc;
    state     = state_q;
    ret_addr  = ret_addr_q;
    bus_fault = bus_fault_q;
    undef     = undef_q;
  end

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] enc_state;
  logic [2:0] n_sel;
  logic [5:0] cr_addr;
  logic       inv;
  logic       cond_true;
  logic       moc;
  logic [5:0] state;
  logic [5:0] ret_addr;
  logic       moc_wait;
  logic       bus_fault;
  logic       undef;

  int total = 0;
  int bad   = 0;

  microsequencer #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enc_state (enc_state),
    .n_sel     (n_sel),
    .cr_addr   (cr_addr),
    .inv       (inv),
    .cond_true (cond_true),
    .moc       (moc),
    .state     (state),
    .ret_addr  (ret_addr),
    .moc_wait  (moc_wait),
    .bus_fault (bus_fault),
    .undef     (undef)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ns, input logic [5:0] cr,
                       input logic [5:0] enc, input logic c, input logic i,
                       input logic m);
    n_sel = ns; cr_addr = cr; enc_state = enc; cond_true = c; inv = i; moc = m;
    #1;
  endtask

  task automatic jump_to(input logic [5:0] a);
    drive(NS_JUMP, a, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== a) begin bad++; $display("FAIL jump_to: state=%0d want %0d", state, a); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(NS_HOLD, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    total++;
    if (state !== 6'd0) begin bad++; $display("FAIL reset_state: state=%0d want 0", state); end
    total++;
    if (ret_addr !== 6'd0) begin bad++; $display("FAIL reset_ret: ret_addr=%0d want 0", ret_addr); end
    total++;
    if ({bus_fault, undef, moc_wait} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: bf/undef/mw=%b want 000", {bus_fault, undef, moc_wait});
    end
  endtask

  task automatic test_decode();
    reset = 1'b0;
    drive(NS_DECODE, 6'd0, 6'd5, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd5 || undef !== 1'b0) begin
      bad++; $display("FAIL decode5: state=%0d undef=%b want 5/0", state, undef);
    end
    drive(NS_DECODE, 6'd0, 6'd63, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd63 || undef !== 1'b1) begin
      bad++; $display("FAIL decode63: state=%0d undef=%b want 63/1", state, undef);
    end
    drive(NS_INC, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd0 || undef !== 1'b0) begin
      bad++; $display("FAIL undef_pulse: state=%0d undef=%b want 0/0", state, undef);
    end
  endtask

  task automatic test_cjump();
    logic [3:0] vec [4];
    logic [5:0] want [4];
    // {cond_true, inv} -> expected target from state 8, cr_addr 20
    vec[0] = 4'b0010; want[0] = 6'd20;
    vec[1] = 4'b0011; want[1] = 6'd9;
    vec[2] = 4'b0001; want[2] = 6'd20;
    vec[3] = 4'b0000; want[3] = 6'd9;
    for (int k = 0; k < 4; k++) begin
      jump_to(6'd8);
      drive(NS_CJUMP, 6'd20, 6'd0, vec[k][1], vec[k][0], 1'b0);
      cyc();
      total++;
      if (state !== want[k]) begin
        bad++; $display("FAIL cjump[%0d]: state=%0d want %0d", k, state, want[k]);
      end
    end
  endtask

  task automatic test_moc_wait();
    jump_to(6'd16);
    drive(NS_WAIT, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (moc_wait !== 1'b1) begin bad++; $display("FAIL wait_flag[%0d]: moc_wait=%b want 1", k, moc_wait); end
      cyc();
      total++;
      if (state !== 6'd16) begin bad++; $display("FAIL wait_hold[%0d]: state=%0d want 16", k, state); end
    end
    drive(NS_WAIT, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (moc_wait !== 1'b0) begin bad++; $display("FAIL wait_release_flag: moc_wait=%b want 0", moc_wait); end
    cyc();
    total++;
    if (state !== 6'd17 || bus_fault !== 1'b0) begin
      bad++; $display("FAIL wait_release: state=%0d bf=%b want 17/0", state, bus_fault);
    end
  endtask

  task automatic test_moc_wins();
    jump_to(6'd16);
    drive(NS_WAIT, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) cyc();
    total++;
    if (state !== 6'd16) begin bad++; $display("FAIL late_moc_hold: state=%0d want 16", state); end
    drive(NS_WAIT, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    cyc();
    total++;
    if (state !== 6'd17 || bus_fault !== 1'b0) begin
      bad++; $display("FAIL late_moc: state=%0d bf=%b want 17/0", state, bus_fault);
    end
  endtask

  task automatic test_reset_mid_wait_and_timeout();
    jump_to(6'd16);
    drive(NS_WAIT, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc();
    reset = 1'b1;  // during the 4th stalled cycle, WAIT stays selected
    cyc();
    total++;
    if (state !== 6'd0 || bus_fault !== 1'b0) begin
      bad++; $display("FAIL reset_mid_wait: state=%0d bf=%b want 0/0", state, bus_fault);
    end
    reset = 1'b0;
    repeat (7) cyc();
    total++;
    if (state !== 6'd0 || bus_fault !== 1'b0) begin
      bad++; $display("FAIL pre_timeout: state=%0d bf=%b want 0/0", state, bus_fault);
    end
    cyc();
    total++;
    if (state !== 6'd62 || bus_fault !== 1'b1) begin
      bad++; $display("FAIL timeout: state=%0d bf=%b want 62/1", state, bus_fault);
    end
    jump_to(6'd5);
    total++;
    if (bus_fault !== 1'b1) begin bad++; $display("FAIL sticky1: bf=%b want 1", bus_fault); end
    jump_to(6'd10);
    total++;
    if (bus_fault !== 1'b1) begin bad++; $display("FAIL sticky2: bf=%b want 1", bus_fault); end
  endtask

  task automatic test_call_ret();
    jump_to(6'd30);
    drive(NS_CALL, 6'd40, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd40 || ret_addr !== 6'd31) begin
      bad++; $display("FAIL call: state=%0d ret=%0d want 40/31", state, ret_addr);
    end
    drive(NS_INC, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(NS_RET, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd31 || ret_addr !== 6'd31) begin
      bad++; $display("FAIL ret: state=%0d ret=%0d want 31/31", state, ret_addr);
    end
    jump_to(6'd50);
    drive(NS_CALL, 6'd2, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(NS_RET, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd51 || ret_addr !== 6'd51) begin
      bad++; $display("FAIL recall: state=%0d ret=%0d want 51/51", state, ret_addr);
    end
    jump_to(6'd63);
    drive(NS_INC, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    total++;
    if (state !== 6'd0) begin bad++; $display("FAIL wrap: state=%0d want 0", state); end
  endtask

  task automatic test_hold();
    jump_to(6'd7);
    drive(NS_HOLD, 6'd33, 6'd33, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc();
    total++;
    if (state !== 6'd7) begin bad++; $display("FAIL hold: state=%0d want 7", state); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if (state !== 6'd0 || bus_fault !== 1'b0) begin
      bad++; $display("FAIL hold_reset: state=%0d bf=%b want 0/0", state, bus_fault);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(NS_HOLD, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_decode();
    test_cjump();
    test_moc_wait();
    test_moc_wins();
    test_reset_mid_wait_and_timeout();
    test_call_ret();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
